serial_adder: RTL and testbench

- Bit-serial two-operand adder. Accepts a pair of WIDTH-bit operands on a start/ready handshake.
- Adds them LSB-first, one bit per clock, using a single full-adder slice and a carry flip-flop.
- Presents sum and carry-out on a valid/ack handshake.
- Sits downstream of the 1-bit adder cell: it chains that cell's sum/carry behaviour over time into a multi-bit result, for area-constrained datapaths.

---
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Handshake bundle for the bit-serial adder: operand request
//               side (start/ready) and result side (valid/ack).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             valid;
    logic             ack;

    // Requester/consumer side: supplies operands and acknowledges results
    modport master (
        output start, a, b, ack,
        input  ready, busy, sum, cout, valid
    );

    // Adder side
    modport slave (
        input  start, a, b, ack,
        output ready, busy, sum, cout, valid
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder. One full-adder slice plus a carry
//               flop processes the operands LSB-first, one bit per clock;
//               the WIDTH-bit sum and carry-out are presented on valid/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_ready;
    logic             w_busy;
    logic             w_valid;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_last       = (r_cnt == c_last_bit);
    assign w_sum_bit    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry_next = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    // Result register shifts right; the new sum bit enters at the MSB so that
    // after WIDTH steps bit i sits at position i.
    always_comb begin
        w_res_next            = r_res_sh >> 1;
        w_res_next[WIDTH-1]   = w_sum_bit;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Serial datapath: operand capture, one bit per step, result publish on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_load) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            r_carry  <= w_carry_next;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_carry_next;
            end
        end
    end

    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
    assign bus.valid = w_valid;
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
//               A cycle-level behavioural model of the 8-bit instance is
//               compared against the DUT at every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   check_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the 8-bit instance: phase 0 idle, 1 computing, 2 result held.
    // The result is plain integer addition once WIDTH compute edges have elapsed.
    int         m_phase;
    int         m_left;
    logic [7:0] m_a, m_b, m_sum;
    logic       m_cout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (if8.start) begin
                    m_a     <= if8.a;
                    m_b     <= if8.b;
                    m_left  <= 8;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        {m_cout, m_sum} <= 9'(m_a) + 9'(m_b);
                        m_phase         <= 2;
                    end
                end
                default: if (if8.ack) m_phase <= 0;
            endcase
        end
    end

    // Compare DUT against model and check handshake exclusivity every cycle
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("model8", 64'({if8.ready, if8.busy, if8.valid, if8.cout, if8.sum}),
                  64'({m_phase == 0, m_phase == 1, m_phase == 2, m_cout, m_sum}));
            check("onehot8", 64'($onehot({if8.ready, if8.busy, if8.valid})), 64'(1));
            check("onehot1", 64'($onehot({if1.ready, if1.busy, if1.valid})), 64'(1));
        end
    end

    // One 8-bit operation starting from idle; inputs change 1 time unit after edges.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int dly, input bit noisy,
                       output logic [7:0] s, output logic c, output int lat);
        if8.a     = x;
        if8.b     = y;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (noisy && !if8.valid) begin
                if8.a     = 8'($urandom);
                if8.b     = 8'($urandom);
                if8.start = 1'($urandom_range(0, 1));
                if8.ack   = 1'($urandom_range(0, 1));
            end
        end while (!if8.valid && lat < 64);
        if8.ack = 1'b0;
        if (!if8.valid) check("valid_timeout", 64'(0), 64'(1));
        s = if8.sum;
        c = if8.cout;
        for (int k = 0; k < dly; k++) begin
            @(posedge clk); #1;
            if (noisy) if8.start = 1'($urandom_range(0, 1));
        end
        if8.ack = 1'b1;
        @(posedge clk); #1;
        if8.ack   = 1'b0;
        if8.start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic       c;
        int         lat;
        int         n;
        logic [3:0] t_sum  = 4'b0110;
        logic [3:0] t_cout = 4'b1000;

        if8.start = 0; if8.a = 0; if8.b = 0; if8.ack = 0;
        if1.start = 0; if1.a = 0; if1.b = 0; if1.ack = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_hs", 64'({if8.ready, if8.busy, if8.valid}), 64'(3'b100));
        check("reset_res", 64'({if8.cout, if8.sum}), 64'(0));
        rst_n    = 1'b1;
        check_en = 1'b1;
        @(posedge clk); #1;

        // Basic additions with hand-computed results
        op8(8'h0F, 8'h01, 0, 1'b0, s, c, lat);
        check("lat_0f01", 64'(lat), 64'(8));
        check("sum_0f01", 64'({c, s}), 64'(9'h010));
        check("ready_after_ack", 64'({if8.ready, if8.valid}), 64'(2'b10));
        op8(8'hFF, 8'h01, 1, 1'b0, s, c, lat);
        check("sum_ff01", 64'({c, s}), 64'(9'h100));
        op8(8'hFF, 8'hFF, 2, 1'b0, s, c, lat);
        check("sum_ffff", 64'({c, s}), 64'(9'h1FE));
        op8(8'h00, 8'h00, 0, 1'b0, s, c, lat);
        check("sum_0000", 64'({c, s}), 64'(9'h000));

        // start held, operands disturbed mid-operation, long ack stall
        if8.a = 8'h5A; if8.b = 8'h33; if8.start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!if8.valid && n < 64) begin
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("hold_lat", 64'(n), 64'(8));
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("hold_stable", 64'({if8.valid, if8.cout, if8.sum}), 64'({1'b1, 1'b0, 8'h8D}));
        end
        if8.ack = 1'b1;
        @(posedge clk); #1;
        if8.ack = 1'b0;
        check("ack_with_start", 64'({if8.ready, if8.busy, if8.valid}), 64'(3'b100));
        if8.a = 8'h01; if8.b = 8'h02;
        @(posedge clk); #1;
        check("restart_busy", 64'(if8.busy), 64'(1));
        if8.start = 1'b0;
        n = 0;
        while (!if8.valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("sum_0102", 64'({if8.cout, if8.sum}), 64'(9'h003));
        if8.ack = 1'b1;
        @(posedge clk); #1;
        if8.ack = 1'b0;

        // Asynchronous reset in the middle of an operation
        if8.a = 8'hAB; if8.b = 8'hCD; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_hs", 64'({if8.ready, if8.busy, if8.valid}), 64'(3'b100));
        check("midreset_res", 64'({if8.cout, if8.sum}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h12, 8'h34, 0, 1'b0, s, c, lat);
        check("sum_1234", 64'({c, s}), 64'(9'h046));

        // WIDTH=1 sweep: registered full adder with carry-in 0
        for (int i = 0; i < 4; i++) begin
            if1.a     = 1'(i >> 1);
            if1.b     = 1'(i);
            if1.start = 1'b1;
            @(posedge clk); #1;
            if1.start = 1'b0;
            check("w1_busy", 64'(if1.busy), 64'(1));
            @(posedge clk); #1;
            check("w1_valid", 64'(if1.valid), 64'(1));
            check("w1_result", 64'({if1.cout, if1.sum}), 64'({t_cout[i], t_sum[i]}));
            if1.ack = 1'b1;
            @(posedge clk); #1;
            if1.ack = 1'b0;
            check("w1_ready", 64'(if1.ready), 64'(1));
        end

        // Randomised regression
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            op8(x, y, int'($urandom_range(0, 5)), 1'b1, s, c, lat);
            check("rand_lat", 64'(lat), 64'(8));
            check("rand_sum", 64'({c, s}), 64'(9'(x) + 9'(y)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
